// File: rtl/life_grid_scanner.sv
// rtl/life_grid_scanner.sv - snapshot/double-buffered row scanner for the life cell array LED matrix
//
// Purpose:
//   Captures the cell array's live bits into a shadow register on request.
//   Copies the shadow into the display register only at frame wrap, so a frame never tears.
//   Scans the display register one row at a time: DWELL lit cycles, then BLANK dark cycles.
//
// Ports:
//   Clock          rising-edge clock
//   reset          synchronous, active-high
//   cells_i        live cell bits, cell (r,c) = cells_i[r*COLS+c]
//   snap_i         capture request, sampled every edge
//   snap_ack_o     one-cycle pulse the cycle after a sampled snap_i
//   row_sel_o      one-hot active row, zero when idle or blanking
//   col_data_o     display bits of the active row, zero when row_sel_o is zero
//   frame_done_o   one-cycle pulse during the last blanking cycle of a frame
//   population_o   registered live count of the display register
//                  (only when LIFE_SCAN_POPCOUNT_EN is defined)
//
// Optional feature macro: LIFE_SCAN_POPCOUNT_EN
module life_grid_scanner #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] cells_i,
    input  logic                 snap_i,
    output logic                 snap_ack_o,
    output logic [ROWS-1:0]      row_sel_o,
    output logic [COLS-1:0]      col_data_o,
    output logic                 frame_done_o
`ifdef LIFE_SCAN_POPCOUNT_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] population_o
`endif
);

    localparam int CELLS = ROWS * COLS;
    localparam int TMAX  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RW    = $clog2(ROWS);

    localparam logic [TW-1:0]   DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0]   BLANK_LAST = TW'(BLANK - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_ONE    = ROWS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        BLNK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [CELLS-1:0] shadow_q, shadow_d;
    logic [CELLS-1:0] disp_q, disp_d;

    logic            snap_ack_q, snap_ack_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [COLS-1:0] col_data_q, col_data_d;
    logic            frame_done_q, frame_done_d;

    // Next-state logic. Outputs are derived from the next state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        tick_d   = tick_q;
        shadow_d = snap_i ? cells_i : shadow_q;
        disp_d   = disp_q;

        unique case (state_q)
            IDLE: begin
                if (snap_i) begin
                    disp_d  = cells_i;
                    row_d   = '0;
                    tick_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (tick_q == DWELL_LAST) begin
                    tick_d  = '0;
                    state_d = BLNK;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            BLNK: begin
                if (tick_q == BLANK_LAST) begin
                    tick_d  = '0;
                    state_d = SCAN;
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        // Frame wrap: a capture on this very edge bypasses the
                        // shadow so the newest data is shown immediately.
                        row_d  = '0;
                        disp_d = snap_i ? cells_i : shadow_q;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        snap_ack_d   = snap_i;
        row_sel_d    = (state_d == SCAN) ? (ROW_ONE << row_d) : '0;
        col_data_d   = (state_d == SCAN) ? disp_d[row_d*COLS +: COLS] : '0;
        frame_done_d = (state_d == BLNK) && (tick_d == BLANK_LAST) && (row_d == ROW_LAST);
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            tick_q       <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            snap_ack_q   <= 1'b0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            tick_q       <= tick_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            snap_ack_q   <= snap_ack_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign snap_ack_o   = snap_ack_q;
    assign row_sel_o    = row_sel_q;
    assign col_data_o   = col_data_q;
    assign frame_done_o = frame_done_q;

`ifdef LIFE_SCAN_POPCOUNT_EN
    localparam int PW = $clog2(CELLS + 1);

    logic [PW-1:0] population_q;

    function automatic logic [PW-1:0] popcount(input logic [CELLS-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < CELLS; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Counts the display register as it stands, so it trails each disp load by one cycle.
    always_ff @(posedge Clock) begin
        if (reset) begin
            population_q <= '0;
        end else begin
            population_q <= popcount(disp_q);
        end
    end

    assign population_o = population_q;
`endif

endmodule

// File: tb/tb_life_grid_scanner.sv
// tb/tb_life_grid_scanner.sv - self-checking bench for life_grid_scanner
module tb_life_grid_scanner;

    logic         Clock;
    logic         reset;
    logic [255:0] cells_i;
    logic         snap_i;
    logic         snap_ack_o;
    logic [15:0]  row_sel_o;
    logic [15:0]  col_data_o;
    logic         frame_done_o;
`ifdef LIFE_SCAN_POPCOUNT_EN
    logic [8:0]   population_o;
`endif

    life_grid_scanner dut (
        .Clock        (Clock),
        .reset        (reset),
        .cells_i      (cells_i),
        .snap_i       (snap_i),
        .snap_ack_o   (snap_ack_o),
        .row_sel_o    (row_sel_o),
        .col_data_o   (col_data_o),
        .frame_done_o (frame_done_o)
`ifdef LIFE_SCAN_POPCOUNT_EN
        ,
        .population_o (population_o)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    typedef struct {
        int          k;
        logic [15:0] rs;
        logic [15:0] cd;
        logic        ack;
        logic        fd;
    } vec_t;

    vec_t vecs[12];

    logic [255:0] img[5];
    logic [255:0] glider, pat_a, pat_b, pat_c;

    function automatic logic [15:0] exp_rs(input int k);
        int pos;
        logic [15:0] one;
        one = 16'h0001;
        pos = (k - 1) % 80;
        return ((pos % 5) < 4) ? (one << (pos / 5)) : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_cd(input int k, input logic [255:0] im);
        int pos;
        pos = (k - 1) % 80;
        return ((pos % 5) < 4) ? im[(pos / 5) * 16 +: 16] : 16'h0000;
    endfunction

    initial begin
        logic prev_snap;
        int   f;

        glider = '0;
        glider[15:0]  = 16'h0002;
        glider[31:16] = 16'h0004;
        glider[47:32] = 16'h0007;
        pat_a = {16{16'hAAAA}};
        pat_b = {16{16'h5555}};
        for (int r = 0; r < 16; r++) pat_c[r*16 +: 16] = 16'h8000 >> r;

        img[0] = glider;
        img[1] = glider;
        img[2] = {256{1'b1}};
        img[3] = '0;
        img[4] = pat_c;

        vecs[0]  = '{1,  16'h0001, 16'h0002, 1'b1, 1'b0};
        vecs[1]  = '{4,  16'h0001, 16'h0002, 1'b0, 1'b0};
        vecs[2]  = '{5,  16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{6,  16'h0002, 16'h0004, 1'b0, 1'b0};
        vecs[4]  = '{9,  16'h0002, 16'h0004, 1'b0, 1'b0};
        vecs[5]  = '{10, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{11, 16'h0004, 16'h0007, 1'b0, 1'b0};
        vecs[7]  = '{16, 16'h0008, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{80, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{81, 16'h0001, 16'h0002, 1'b0, 1'b0};
        vecs[10] = '{161, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{241, 16'h0001, 16'h0000, 1'b1, 1'b0};

        reset   = 1'b1;
        snap_i  = 1'b0;
        cells_i = '0;
        repeat (3) @(posedge Clock);
        #1;
        reset = 1'b0;
        chk("rst_row_sel", 0, 32'(row_sel_o), 32'h0);
        chk("rst_col_data", 0, 32'(col_data_o), 32'h0);
        chk("rst_frame_done", 0, 32'(frame_done_o), 32'h0);
        chk("rst_snap_ack", 0, 32'(snap_ack_o), 32'h0);
`ifdef LIFE_SCAN_POPCOUNT_EN
        chk("rst_population", 0, 32'(population_o), 32'h0);
`endif

        for (int i = 0; i < 100; i++) begin
            @(posedge Clock);
            #1;
            chk("idle_row_sel", i, 32'(row_sel_o), 32'h0);
            chk("idle_col_data", i, 32'(col_data_o), 32'h0);
            chk("idle_frame_done", i, 32'(frame_done_o), 32'h0);
        end

        cells_i = glider;
        snap_i  = 1'b1;
        @(posedge Clock);
        #1;
        prev_snap = 1'b1;

        for (int k = 1; k <= 360; k++) begin
            f = (k - 1) / 80;
            chk("row_sel", k, 32'(row_sel_o), 32'(exp_rs(k)));
            chk("col_data", k, 32'(col_data_o), 32'(exp_cd(k, img[f])));
            chk("frame_done", k, 32'(frame_done_o), 32'(((k - 1) % 80) == 79));
            chk("snap_ack", k, 32'(snap_ack_o), 32'(prev_snap));
`ifdef LIFE_SCAN_POPCOUNT_EN
            chk("population", k, 32'(population_o),
                (k == 1) ? 32'h0 : 32'($countones(img[(k - 2) / 80])));
`endif
            for (int v = 0; v < 12; v++) begin
                if (vecs[v].k == k) begin
                    chk("vec_row_sel", k, 32'(row_sel_o), 32'(vecs[v].rs));
                    chk("vec_col_data", k, 32'(col_data_o), 32'(vecs[v].cd));
                    chk("vec_snap_ack", k, 32'(snap_ack_o), 32'(vecs[v].ack));
                    chk("vec_frame_done", k, 32'(frame_done_o), 32'(vecs[v].fd));
                end
            end

            snap_i = 1'b0;
            case (k)
                110: begin cells_i = {256{1'b1}}; snap_i = 1'b1; end
                111: cells_i = '0;
                240: begin cells_i = '0; snap_i = 1'b1; end
                250: begin cells_i = pat_a; snap_i = 1'b1; end
                251: begin cells_i = pat_b; snap_i = 1'b1; end
                252: begin cells_i = pat_c; snap_i = 1'b1; end
                253: cells_i = glider;
                360: reset = 1'b1;
                default: ;
            endcase
            prev_snap = snap_i;
            @(posedge Clock);
            #1;
        end

        reset = 1'b0;
        chk("midrst_row_sel", 361, 32'(row_sel_o), 32'h0);
        chk("midrst_col_data", 361, 32'(col_data_o), 32'h0);
        chk("midrst_frame_done", 361, 32'(frame_done_o), 32'h0);
        chk("midrst_snap_ack", 361, 32'(snap_ack_o), 32'h0);
`ifdef LIFE_SCAN_POPCOUNT_EN
        chk("midrst_population", 361, 32'(population_o), 32'h0);
`endif
        for (int i = 0; i < 100; i++) begin
            @(posedge Clock);
            #1;
            chk("post_rst_row_sel", 362 + i, 32'(row_sel_o), 32'h0);
            chk("post_rst_frame_done", 362 + i, 32'(frame_done_o), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
